load_store_unit: RTL

- Sits between the EX/MEM pipeline register and data_memory in the MEM stage.
- Drives data_memory's address, write data, funct3, MemWrite and MemRead.
- Returns sign- or zero-extended load data to MEM/WB.
- Aligned accesses pass through in one cycle. Misaligned halfword and word accesses are split into sequential byte accesses, and the pipeline is stalled until the split completes.

---
 rtl/core_pkg.sv | 39 +++
 rtl/load_store_unit_if.sv | 14 +
 rtl/load_store_unit_extender.sv | 34 +++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: data width, RV32I load/store funct3 codes and LSU state encoding.
// The load/store unit's optional trap mode is selected by defining MISALIGN_TRAP_EN.
package core_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  localparam logic [2:0] FUNCT3_LOAD_B  = 3'b000;
  localparam logic [2:0] FUNCT3_LOAD_H  = 3'b001;
  localparam logic [2:0] FUNCT3_LOAD_W  = 3'b010;
  localparam logic [2:0] FUNCT3_LOAD_BU = 3'b100;
  localparam logic [2:0] FUNCT3_LOAD_HU = 3'b101;

  typedef enum logic {LSU_IDLE, LSU_SPLIT} lsu_state_e;

  // 101 is LHU for loads but has no store meaning, so it only splits on loads.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset,
                                         input logic store);
    logic mis;
    mis = 1'b0;
    case (funct3)
      FUNCT3_LOAD_H:  mis = offset[0];
      FUNCT3_LOAD_HU: mis = ~store & offset[0];
      FUNCT3_LOAD_W:  mis = |offset;
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Index of the final byte of a split: halfwords take 2 bytes, words 4.
  function automatic logic [1:0] split_last(input logic [2:0] funct3);
    return (funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data_memory (slave).
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [2:0]            mem_funct3;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_funct3, MemWrite, MemRead, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_funct3, MemWrite, MemRead, output mem_rdata);
endinterface

// File: rtl/load_store_unit_extender.sv
// load_extender: picks the byte/half/word out of a memory word and sign- or zero-extends it.
module load_extender #(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0]             word,
  input  logic [$clog2(BYTES_PER_WORD)-1:0] offset,
  input  logic [2:0]                        funct3,
  output logic [DATA_WIDTH-1:0]             result
);
  import core_pkg::*;

  localparam int OFFW = $clog2(BYTES_PER_WORD);

  logic [BYTES_PER_WORD-1:0][7:0] lanes;
  logic [7:0]                     b;
  logic [15:0]                    h;

  assign lanes = word;
  assign b     = lanes[offset];
  assign h     = {lanes[{offset[OFFW-1:1], 1'b1}], lanes[{offset[OFFW-1:1], 1'b0}]};

  always_comb begin
    result = '0;
    case (funct3)
      FUNCT3_LOAD_B:  result = {{(DATA_WIDTH-8){b[7]}}, b};
      FUNCT3_LOAD_BU: result = {{(DATA_WIDTH-8){1'b0}}, b};
      FUNCT3_LOAD_H:  result = {{(DATA_WIDTH-16){h[15]}}, h};
      FUNCT3_LOAD_HU: result = {{(DATA_WIDTH-16){1'b0}}, h};
      FUNCT3_LOAD_W:  result = word;
      default:        result = '0;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: aligned accesses pass straight through, misaligned ones are split
// into byte accesses while the pipeline stalls. Define MISALIGN_TRAP_EN to trap instead of split.
module load_store_unit #(
  parameter int DATA_WIDTH     = core_pkg::DATA_WIDTH,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [2:0]            req_funct3_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  load_store_unit_if.master     mem,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  stall_o,
  output logic                  misalign_exc_o
);
  import core_pkg::*;

  localparam int OFFW = $clog2(BYTES_PER_WORD);
`ifdef MISALIGN_TRAP_EN
  localparam bit SPLIT_EN = 1'b0;
`else
  localparam bit SPLIT_EN = 1'b1;
`endif

  lsu_state_e                     state;
  logic [OFFW-1:0]                cnt, last_k, ext_off;
  logic [BYTES_PER_WORD-1:0][7:0] acc, merged, rd_lanes, lat_wdata;
  logic [DATA_WIDTH-1:0]          lat_addr, split_addr, ext_word, ext_result;
  logic [2:0]                     lat_funct3, ext_funct3;
  logic                           lat_store;
  logic                           req_store, req_load, req_mis, split_start;
  logic [7:0]                     rd_byte;

  // A store wins when both enables are raised.
  assign req_store   = MemWrite_i;
  assign req_load    = MemRead_i & ~MemWrite_i;
  assign req_mis     = (req_store | req_load) &
                       is_misaligned(req_funct3_i, req_addr_i[1:0], req_store);
  assign split_start = SPLIT_EN & req_mis & (state == LSU_IDLE);

  assign rd_lanes   = mem.mem_rdata;
  assign split_addr = lat_addr + DATA_WIDTH'(cnt);
  assign last_k     = split_last(lat_funct3);
  assign rd_byte    = (state == LSU_SPLIT) ? rd_lanes[split_addr[OFFW-1:0]]
                                           : rd_lanes[req_addr_i[OFFW-1:0]];

  // Accumulator with the byte being read this cycle dropped into slot cnt.
  for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_merge
    assign merged[g] = (cnt == OFFW'(g)) ? rd_byte : acc[g];
  end

  // The split result is assembled LSB-first, so it is extended from offset 0.
  assign ext_word   = (state == LSU_SPLIT) ? merged     : mem.mem_rdata;
  assign ext_off    = (state == LSU_SPLIT) ? '0         : req_addr_i[OFFW-1:0];
  assign ext_funct3 = (state == LSU_SPLIT) ? lat_funct3 : req_funct3_i;

  load_extender #(.DATA_WIDTH(DATA_WIDTH), .BYTES_PER_WORD(BYTES_PER_WORD)) u_ext (
    .word   (ext_word),
    .offset (ext_off),
    .funct3 (ext_funct3),
    .result (ext_result)
  );

  always_comb begin
    mem.mem_addr   = req_addr_i;
    mem.mem_wdata  = req_wdata_i;
    mem.mem_funct3 = req_funct3_i;
    mem.MemWrite   = 1'b0;
    mem.MemRead    = 1'b0;
    load_data_o    = '0;
    stall_o        = 1'b0;
    misalign_exc_o = 1'b0;
    // Enables are gated by reset so an aborted split cannot write any further bytes.
    if (!rst_n) begin
      mem.MemWrite = 1'b0;
    end else if (state == LSU_SPLIT) begin
      mem.mem_addr   = split_addr;
      mem.mem_funct3 = FUNCT3_SB;
      mem.mem_wdata  = {{(DATA_WIDTH-8){1'b0}}, lat_wdata[cnt]};
      mem.MemWrite   = lat_store;
      mem.MemRead    = ~lat_store;
      stall_o        = (cnt != last_k);
      if (cnt == last_k && !lat_store)
        load_data_o = ext_result;
    end else if (req_mis) begin
`ifdef MISALIGN_TRAP_EN
      misalign_exc_o = 1'b1;
`else
      mem.mem_funct3 = FUNCT3_SB;
      mem.mem_wdata  = {{(DATA_WIDTH-8){1'b0}}, req_wdata_i[7:0]};
      mem.MemWrite   = req_store;
      mem.MemRead    = req_load;
      stall_o        = 1'b1;
`endif
    end else begin
      mem.MemWrite = req_store;
      mem.MemRead  = req_load;
      if (req_load)
        load_data_o = ext_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LSU_IDLE;
      cnt        <= '0;
      acc        <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      lat_store  <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (split_start) begin
            lat_addr   <= req_addr_i;
            lat_wdata  <= req_wdata_i;
            lat_funct3 <= req_funct3_i;
            lat_store  <= req_store;
            acc        <= '0;
            acc[0]     <= rd_byte;
            cnt        <= OFFW'(1);
            state      <= LSU_SPLIT;
          end
        end
        LSU_SPLIT: begin
          if (cnt == last_k) begin
            cnt   <= '0;
            state <= LSU_IDLE;
          end else begin
            acc <= merged;
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end
endmodule
